// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle CPU datapath and its main control FSM.
// The controller takes the master view: it samples Op/Func/Zero and drives every control line.
interface multicycle_ctrl_if;
    logic [3:0] Op;
    logic [8:0] Func;
    logic       Zero;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       retire;
    logic       halted;
    logic       illegal;
    logic [3:0] state_o;

    modport master (
        input  Op, Func, Zero,
        output pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, retire, halted,
               illegal, state_o
    );

    modport slave (
        output Op, Func, Zero,
        input  pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, retire, halted,
               illegal, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the 16-bit multicycle CPU: sequences fetch/decode/execute/memory/write-back
// and drives all datapath selects and write enables from registered, state-decoded outputs.
module multicycle_ctrl #(
    parameter int unsigned PC_INC = 1
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        LOAD_RD  = 4'd6,
        LOAD_WB  = 4'd7,
        STORE    = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        HALT     = 4'd15
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_NOT = 3'b100
    } alu_op_t;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       retire;
        logic       halted;
    } ctrl_t;

    // The ALU B-input increment constant lives in the datapath; a zero step is meaningless.
    if (PC_INC == 0) begin : g_pc_inc_chk
        $error("multicycle_ctrl: PC_INC must be nonzero");
    end

    state_t state;
    state_t nxt;
    logic   ill_set;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl;
    logic   illegal_q;

    function automatic logic func_ok(input logic [8:0] f);
        return f inside {9'h001, 9'h002, 9'h004, 9'h008, 9'h010};
    endfunction

    function automatic alu_op_t r_alu_op(input logic [8:0] f);
        if (f[0])      return ALU_ADD;
        else if (f[1]) return ALU_SUB;
        else if (f[2]) return ALU_AND;
        else if (f[3]) return ALU_OR;
        else           return ALU_NOT;
    endfunction

    function automatic alu_op_t i_alu_op(input logic [3:0] op);
        case (op)
            4'b0010: return ALU_SUB;
            4'b0011: return ALU_AND;
            4'b0100: return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

    // Outputs for the state being entered; Op/Func are stable whenever they matter here.
    function automatic ctrl_t decode(input state_t s, input logic [3:0] op, input logic [8:0] func);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            DECODE:   c.alu_src_b = 2'b10;
            EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = r_alu_op(func);
            end
            EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = i_alu_op(op);
            end
            ALU_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = (op == 4'b0000);
                c.retire    = 1'b1;
            end
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            LOAD_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            LOAD_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
            end
            STORE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
                c.retire    = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.pc_src    = 2'b01;
                c.retire    = 1'b1;
            end
            JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
                c.retire   = 1'b1;
            end
            HALT:     c.halted = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt     = FETCH;
        ill_set = 1'b0;
        case (state)
            FETCH:  nxt = DECODE;
            DECODE: begin
                case (bus.Op)
                    4'b0000: begin
                        if (func_ok(bus.Func)) begin
                            nxt = EXEC_R;
                        end else begin
                            nxt     = HALT;
                            ill_set = 1'b1;
                        end
                    end
                    4'b0001, 4'b0010, 4'b0011, 4'b0100: nxt = EXEC_I;
                    4'b0101, 4'b0110:                   nxt = MEM_ADDR;
                    4'b0111:                            nxt = JUMP;
                    4'b1000:                            nxt = BRANCH;
                    4'b1111:                            nxt = HALT;
                    default: begin
                        nxt     = HALT;
                        ill_set = 1'b1;
                    end
                endcase
            end
            EXEC_R, EXEC_I: nxt = ALU_WB;
            MEM_ADDR: nxt = (bus.Op == 4'b0101) ? LOAD_RD : STORE;
            LOAD_RD:  nxt = LOAD_WB;
            HALT:     nxt = HALT;
            default:  nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= FETCH;
            ctrl_q    <= decode(FETCH, bus.Op, bus.Func);
            illegal_q <= 1'b0;
        end else begin
            state  <= nxt;
            ctrl_q <= decode(nxt, bus.Op, bus.Func);
            if (ill_set) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Registered outputs are masked by reset so no write can leak while it is held low.
    assign ctrl = reset ? ctrl_q : '0;

    assign bus.pc_write   = ctrl.pc_write | (reset & (state == BRANCH) & bus.Zero);
    assign bus.iord       = ctrl.iord;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.retire     = ctrl.retire;
    assign bus.halted     = ctrl.halted;
    assign bus.illegal    = reset & illegal_q;
    assign bus.state_o    = reset ? state : 4'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instruction sequences push expected per-cycle
// output vectors; a negedge monitor pops and compares whatever the controller presents.
module tb_multicycle_ctrl;

    typedef logic [22:0] vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.PC_INC(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    vec_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    vec_t act;
    assign act = {bus.state_o, bus.pc_write, bus.iord, bus.mem_read, bus.mem_write,
                  bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_op, bus.pc_src, bus.retire, bus.halted, bus.illegal};

    // Field order: state, pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
    // mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, retire, halted, illegal.
    function automatic vec_t mk(input logic [3:0] st, input logic pcw, input logic iord,
                                input logic mr, input logic mw, input logic irw, input logic rw,
                                input logic rd, input logic mtr, input logic asa,
                                input logic [1:0] asb, input logic [2:0] aop,
                                input logic [1:0] psrc, input logic ret, input logic hlt,
                                input logic ill);
        return {st, pcw, iord, mr, mw, irw, rw, rd, mtr, asa, asb, aop, psrc, ret, hlt, ill};
    endfunction

    vec_t V_ZERO, V_FETCH, V_DECODE, V_EXR_SUB, V_EXR_NOT, V_EXI_AND, V_WB_R, V_WB_I;
    vec_t V_MADDR, V_LDRD, V_LDWB, V_STORE, V_BR_Z1, V_BR_Z0, V_JUMP, V_HALT_ILL, V_HALT_OK;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                         t, act[22:19], act, e[22:19], e);
            end
        end
    end

    task automatic cyc(input logic rst, input logic [3:0] op, input logic [8:0] fn,
                       input logic z, input vec_t e, input string tag);
        @(posedge clk);
        #1;
        reset    = rst;
        bus.Op   = op;
        bus.Func = fn;
        bus.Zero = z;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        V_ZERO     = '0;
        V_FETCH    = mk(4'd0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0, 0, 0);
        V_DECODE   = mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 3'b000, 2'b00, 0, 0, 0);
        V_EXR_SUB  = mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b00, 0, 0, 0);
        V_EXR_NOT  = mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b100, 2'b00, 0, 0, 0);
        V_EXI_AND  = mk(4'd3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0);
        V_WB_R     = mk(4'd4, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b000, 2'b00, 1, 0, 0);
        V_WB_I     = mk(4'd4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 1, 0, 0);
        V_MADDR    = mk(4'd5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0, 0, 0);
        V_LDRD     = mk(4'd6, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0);
        V_LDWB     = mk(4'd7, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 1, 0, 0);
        V_STORE    = mk(4'd8, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 1, 0, 0);
        V_BR_Z1    = mk(4'd9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 1, 0, 0);
        V_BR_Z0    = mk(4'd9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 1, 0, 0);
        V_JUMP     = mk(4'd10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 1, 0, 0);
        V_HALT_ILL = mk(4'd15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1, 1);
        V_HALT_OK  = mk(4'd15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1, 0);

        bus.Op = 4'd0; bus.Func = 9'h000; bus.Zero = 1'b0;

        // Reset held for three cycles, then release straight into FETCH.
        for (int i = 0; i < 3; i++) cyc(0, 4'd0, 9'h000, 0, V_ZERO, "reset_hold");

        // R-type SUB: 0,1,2,4
        cyc(1, 4'b0000, 9'h002, 0, V_FETCH,   "rsub_fetch");
        cyc(1, 4'b0000, 9'h002, 0, V_DECODE,  "rsub_decode");
        cyc(1, 4'b0000, 9'h002, 0, V_EXR_SUB, "rsub_exec");
        cyc(1, 4'b0000, 9'h002, 0, V_WB_R,    "rsub_wb");

        // R-type NOT (highest legal Func bit)
        cyc(1, 4'b0000, 9'h010, 0, V_FETCH,   "rnot_fetch");
        cyc(1, 4'b0000, 9'h010, 0, V_DECODE,  "rnot_decode");
        cyc(1, 4'b0000, 9'h010, 0, V_EXR_NOT, "rnot_exec");
        cyc(1, 4'b0000, 9'h010, 0, V_WB_R,    "rnot_wb");

        // Immediate AND: reg_dst stays 0 in write-back
        cyc(1, 4'b0011, 9'h000, 0, V_FETCH,   "iand_fetch");
        cyc(1, 4'b0011, 9'h000, 0, V_DECODE,  "iand_decode");
        cyc(1, 4'b0011, 9'h000, 0, V_EXI_AND, "iand_exec");
        cyc(1, 4'b0011, 9'h000, 0, V_WB_I,    "iand_wb");

        // Load: 0,1,5,6,7
        cyc(1, 4'b0101, 9'h000, 0, V_FETCH,  "ld_fetch");
        cyc(1, 4'b0101, 9'h000, 0, V_DECODE, "ld_decode");
        cyc(1, 4'b0101, 9'h000, 0, V_MADDR,  "ld_addr");
        cyc(1, 4'b0101, 9'h000, 0, V_LDRD,   "ld_read");
        cyc(1, 4'b0101, 9'h000, 0, V_LDWB,   "ld_wb");

        // Store: 0,1,5,8
        cyc(1, 4'b0110, 9'h000, 0, V_FETCH,  "st_fetch");
        cyc(1, 4'b0110, 9'h000, 0, V_DECODE, "st_decode");
        cyc(1, 4'b0110, 9'h000, 0, V_MADDR,  "st_addr");
        cyc(1, 4'b0110, 9'h000, 0, V_STORE,  "st_store");

        // Branch taken, then not taken
        cyc(1, 4'b1000, 9'h000, 0, V_FETCH,  "br1_fetch");
        cyc(1, 4'b1000, 9'h000, 0, V_DECODE, "br1_decode");
        cyc(1, 4'b1000, 9'h000, 1, V_BR_Z1,  "br1_branch");
        cyc(1, 4'b1000, 9'h000, 0, V_FETCH,  "br0_fetch");
        cyc(1, 4'b1000, 9'h000, 0, V_DECODE, "br0_decode");
        cyc(1, 4'b1000, 9'h000, 0, V_BR_Z0,  "br0_branch");

        // Jump: 3 cycles
        cyc(1, 4'b0111, 9'h000, 0, V_FETCH,  "jmp_fetch");
        cyc(1, 4'b0111, 9'h000, 0, V_DECODE, "jmp_decode");
        cyc(1, 4'b0111, 9'h000, 0, V_JUMP,   "jmp_jump");

        // Reset during LOAD_RD: no write-back, FETCH on release
        cyc(1, 4'b0101, 9'h000, 0, V_FETCH,  "abort_fetch");
        cyc(1, 4'b0101, 9'h000, 0, V_DECODE, "abort_decode");
        cyc(1, 4'b0101, 9'h000, 0, V_MADDR,  "abort_addr");
        cyc(0, 4'b0101, 9'h000, 0, V_ZERO,   "abort_in_ldrd");
        cyc(0, 4'b0101, 9'h000, 0, V_ZERO,   "abort_hold");
        cyc(1, 4'b0101, 9'h000, 0, V_FETCH,  "abort_refetch");
        cyc(1, 4'b0101, 9'h000, 0, V_DECODE, "abort_redecode");

        // Reset again, then multi-hot Func -> illegal HALT that persists
        cyc(0, 4'b0000, 9'h003, 0, V_ZERO,     "ill_rst");
        cyc(1, 4'b0000, 9'h003, 0, V_FETCH,    "ill_fetch");
        cyc(1, 4'b0000, 9'h003, 0, V_DECODE,   "ill_decode");
        for (int i = 0; i < 3; i++) cyc(1, 4'b0000, 9'h003, 1, V_HALT_ILL, "ill_halt");

        // Func bit 5 alone is not a legal R-type function
        cyc(0, 4'b0000, 9'h020, 0, V_ZERO,     "f5_rst");
        cyc(1, 4'b0000, 9'h020, 0, V_FETCH,    "f5_fetch");
        cyc(1, 4'b0000, 9'h020, 0, V_DECODE,   "f5_decode");
        cyc(1, 4'b0000, 9'h020, 0, V_HALT_ILL, "f5_halt");

        // Undefined opcode
        cyc(0, 4'b1010, 9'h000, 0, V_ZERO,     "op10_rst");
        cyc(1, 4'b1010, 9'h000, 0, V_FETCH,    "op10_fetch");
        cyc(1, 4'b1010, 9'h000, 0, V_DECODE,   "op10_decode");
        cyc(1, 4'b1010, 9'h000, 0, V_HALT_ILL, "op10_halt");

        // Legal HALT: reset clears the sticky illegal flag
        cyc(0, 4'b1111, 9'h000, 0, V_ZERO,    "hlt_rst");
        cyc(1, 4'b1111, 9'h000, 0, V_FETCH,   "hlt_fetch");
        cyc(1, 4'b1111, 9'h000, 0, V_DECODE,  "hlt_decode");
        for (int i = 0; i < 2; i++) cyc(1, 4'b1111, 9'h000, 0, V_HALT_OK, "hlt_halt");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected vectors left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
